// File: rtl/dec_cs_arbiter.sv
// Round-robin chip-select sequencer driving a 3-to-8 active-low decoder (IDLE/SETUP/ACTIVE/GUARD).
// Optional macro DEC_CS_ARB_EARLY_REL_EN: end ACTIVE early once the winner drops its request.
module dec_cs_arbiter #(
  parameter int DWELL_W      = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [7:0]         req_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               select_a_o,
  output logic               select_b_o,
  output logic               select_c_o,
  output logic               g1_en_o,
  output logic               g2a_en_n_o,
  output logic               g2b_en_n_o,
  output logic [7:0]         gnt_o,
  output logic [2:0]         grant_id_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, GUARD} state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [3:0]         GUARD_LD  = 4'(GUARD_CYCLES);

  state_t             state;
  logic [2:0]         code_q;
  logic [2:0]         last_grant;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [3:0]         guard_cnt;
  logic [2:0]         next_win;
  logic               end_active;
`ifdef DEC_CS_ARB_EARLY_REL_EN
  logic               rel_seen;
`endif

  // First set request strictly after the last grant, wrapping through all eight targets.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    dwell_load = (d == '0) ? DWELL_ONE : d;
  endfunction

  always_comb begin
    next_win   = rr_pick(req_i, last_grant);
`ifdef DEC_CS_ARB_EARLY_REL_EN
    end_active = (dwell_cnt == DWELL_ONE) || rel_seen;
`else
    end_active = (dwell_cnt == DWELL_ONE);
`endif
  end

  assign select_a_o = code_q[0];
  assign select_b_o = code_q[1];
  assign select_c_o = code_q[2];
  assign grant_id_o = code_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      code_q     <= 3'd0;
      last_grant <= 3'd7;
      dwell_cnt  <= '0;
      guard_cnt  <= 4'd0;
      g1_en_o    <= 1'b0;
      g2a_en_n_o <= 1'b1;
      g2b_en_n_o <= 1'b1;
      gnt_o      <= 8'd0;
      busy_o     <= 1'b0;
`ifdef DEC_CS_ARB_EARLY_REL_EN
      rel_seen   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en_i && (req_i != 8'd0)) begin
            state  <= SETUP;
            code_q <= next_win;
            busy_o <= 1'b1;
          end
        end
        SETUP: begin
          state      <= ACTIVE;
          dwell_cnt  <= dwell_load(dwell_i);
          last_grant <= code_q;
          g1_en_o    <= 1'b1;
          g2a_en_n_o <= 1'b0;
          g2b_en_n_o <= 1'b0;
          gnt_o      <= 8'd1 << code_q;
`ifdef DEC_CS_ARB_EARLY_REL_EN
          rel_seen   <= 1'b0;
`endif
        end
        ACTIVE: begin
          if (end_active) begin
            state      <= GUARD;
            dwell_cnt  <= '0;
            guard_cnt  <= GUARD_LD;
            g1_en_o    <= 1'b0;
            g2a_en_n_o <= 1'b1;
            g2b_en_n_o <= 1'b1;
            gnt_o      <= 8'd0;
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_ONE;
          end
`ifdef DEC_CS_ARB_EARLY_REL_EN
          // Registered so the release takes effect one edge after the drop is seen.
          rel_seen <= ~req_i[code_q];
`endif
        end
        GUARD: begin
          if (guard_cnt == 4'd1) begin
            state     <= IDLE;
            guard_cnt <= 4'd0;
            busy_o    <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
